// File: rtl/uart_pkg.sv
// Shared types and parameter legality helpers for the UART blocks.
package uart_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } tx_state_e;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit tx_params_ok(input int clk_div, input int data_bits,
                                      input int fifo_depth, input int parity,
                                      input int stop_bits);
    return (clk_div >= 2) && (data_bits >= 5) && (data_bits <= 9) &&
           (fifo_depth >= 2) && is_pow2(fifo_depth) &&
           (parity >= 0) && (parity <= 2) &&
           ((stop_bits == 1) || (stop_bits == 2));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count; head word is presented combinationally.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_ni,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage carries no reset; emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with configurable framing and a buffered valid/ready write port.
//
// state | meaning
// IDLE  | line high, waiting for a queued word
// START | start bit (low) for CLK_DIV cycles
// DATA  | DATA_BITS data bits, LSB first
// PAR   | parity bit (only when PARITY != 0)
// STOP  | STOP_BITS stop bits; pops the next word on the last cycle if one is queued
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                        clk,
  input  logic                        reset_ni,
  input  logic [DATA_BITS-1:0]        wr_data_i,
  input  logic                        wr_valid_i,
  output logic                        wr_ready_o,
  output logic                        tx_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] level_o
);

  localparam int      CW    = $clog2(CLK_DIV);
  localparam int      BW    = $clog2(DATA_BITS);
  localparam parity_e PMODE = parity_e'(2'(PARITY));

  if (!tx_params_ok(CLK_DIV, DATA_BITS, FIFO_DEPTH, PARITY, STOP_BITS)) begin : g_bad_params
    $error("uart_tx_fifo: illegal parameter combination");
  end

  tx_state_e            state;
  tx_state_e            nxt_state;
  logic [CW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] head;
  logic                 par_bit;
  logic                 tx_q;
  logic                 tx_d;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 baud_end;
  logic                 last_bit;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_ni (reset_ni),
    .push     (wr_valid_i),
    .pop      (pop),
    .wdata    (wr_data_i),
    .rdata    (head),
    .count    (level_o),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign wr_ready_o = !fifo_full;
  assign busy_o     = (state != IDLE) || !fifo_empty;
  assign tx_o       = tx_q;
  assign baud_end   = (baud_cnt == CW'(CLK_DIV - 1));
  assign last_bit   = (bit_cnt == '0);

  always_comb begin
    nxt_state = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          nxt_state = START;
        end
      end
      START: if (baud_end) nxt_state = DATA;
      DATA:  if (baud_end && last_bit) nxt_state = (PMODE != NONE) ? PAR : STOP;
      PAR:   if (baud_end) nxt_state = STOP;
      STOP: begin
        if (baud_end && last_bit) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            nxt_state = START;
          end else begin
            nxt_state = IDLE;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    case (state)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift[0];
      PAR:     tx_d = par_bit;
      default: tx_d = 1'b1;
    endcase
  end

  // bit_cnt counts data bits down, then is reused for the stop bits.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state <= nxt_state;
      tx_q  <= tx_d;
      if (nxt_state != state || baud_end || state == IDLE) baud_cnt <= '0;
      else baud_cnt <= baud_cnt + CW'(1);
      if (pop) begin
        shift   <= head;
        bit_cnt <= BW'(DATA_BITS - 1);
        par_bit <= (PMODE == ODD) ? ~(^head) : ^head;
      end else if (baud_end) begin
        if (state == DATA) begin
          shift   <= shift >> 1;
          bit_cnt <= last_bit ? BW'(STOP_BITS - 1) : bit_cnt - BW'(1);
        end else if (state == STOP && !last_bit) begin
          bit_cnt <= bit_cnt - BW'(1);
        end
      end
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an integrated transmit FIFO. It drives the SoC serial output `tx_o` and is the next-generation replacement for the fixed 8N1, single-byte transmitter. It adds configurable data width, parity, stop bits, baud divisor and a buffered valid/ready write port, so the CPU bus can queue bytes without polling per character.

## Interface
- `CLK_DIV`, 4: clock cycles per serial bit; must be ≥ 2.
- `DATA_BITS`, 8: data bits per frame; legal range 5–9.
- `FIFO_DEPTH`, 16: FIFO entries; must be a power of two, ≥ 2.
- `PARITY`, 0: parity mode; 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: stop bits per frame; 1 or 2.

- `clk` in 1: single clock for the whole block.
- `reset_ni` in 1: asynchronous reset, active low.
- `wr_data_i` in DATA_BITS: byte to queue.
- `wr_valid_i` in 1: write request.
- `wr_ready_o` out 1: FIFO not full; a write is accepted when `wr_valid_i && wr_ready_o` at a rising edge.
- `tx_o` out 1: serial line, idle high.
- `busy_o` out 1: a frame is in progress or the FIFO is non-empty.
- `level_o` out $clog2(FIFO_DEPTH)+1: number of FIFO entries; excludes the frame in flight.

## Operation
- FIFO:
  - Registered count.
  - `wr_ready_o = (level != FIFO_DEPTH)`, derived from registers only.
  - No write-to-read bypass: a word written in cycle N is first visible to the FSM in cycle N+1.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register, load the bit counter, go to START.
  - START: `tx_o=0` for CLK_DIV cycles, then DATA.
  - DATA: send LSB first, DATA_BITS bits of CLK_DIV cycles each. Then go to PAR if PARITY≠0, else STOP.
  - PAR: even parity bit = XOR of the data; odd parity bit = its inverse. Lasts CLK_DIV cycles.
  - STOP: `tx_o=1` for STOP_BITS×CLK_DIV cycles.
    - On the final stop cycle, if the FIFO is non-empty, pop and go directly to START, so there is no idle gap between frames.
    - Otherwise go to IDLE.
- Frame length: (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLK_DIV cycles.
- Simultaneous write and pop: level stays unchanged; both operations complete.
- FIFO full: the write is ignored (ready is low) and contents are unchanged.
- Baud counter: runs 0..CLK_DIV-1 and wraps; it is reloaded to 0 at every state entry.
- Reset, including mid-frame:
  - All outputs take their reset values immediately.
  - FIFO is emptied and the current frame is abandoned.

## Timing
- Reset values: `tx_o=1`, `wr_ready_o=1`, `busy_o=0`, `level_o=0`, FSM in IDLE.
- Latency from an accepted write to the start bit, starting from IDLE with an empty FIFO:
  - Write accepted at edge N.
  - Pop at edge N+1.
  - `tx_o` falls after edge N+2, i.e. 2 cycles.
- `tx_o` is registered and glitch-free.
- `busy_o` rises with `level_o` going non-zero. It falls on the cycle the FSM enters IDLE with an empty FIFO.
- `level_o` updates one cycle after the write or pop edge.

## Structure
- Package `uart_pkg`:
  - `parity_e` enum (NONE, EVEN, ODD).
  - `tx_state_e` enum (IDLE, START, DATA, PAR, STOP).
  - Parameter legality checks as elaboration assertions.
- Sub-module `sync_fifo`:
  - Parameters WIDTH and DEPTH.
  - Ports: push, pop, data, count, full, empty.
  - Reusable by the future RX block.
- The FSM, shifter and baud counter live in `uart_tx_fifo`.

## Test plan
- Defaults; write 0x55 -> after 2 cycles, `tx_o` runs 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles. Total 40 cycles, then `tx_o=1` and `busy_o` falls.
- PARITY=1; write 0x07 -> parity bit 1. With PARITY=2 the parity bit is 0. Frame is 44 cycles.
- Back-to-back writes 0x00 then 0xFF -> 80 contiguous frame cycles with no extra high cycle between the stop bit and the second start bit.
- Hold `wr_valid_i` continuously -> 17 writes accepted (1 popped, 16 queued). Then `wr_ready_o=0` and `level_o=16`. Ready reasserts the cycle after the next pop, with `level_o=15`.
- Deassert `reset_ni` asynchronously mid DATA bit 3 -> `tx_o=1`, `level_o=0` and `busy_o=0` immediately. After release, a new write of 0xA5 transmits correctly.
- DATA_BITS=5, STOP_BITS=2, CLK_DIV=3; write 0x1F -> frame is 1 start + 5 ones + 2 stop = 24 cycles. Upper bits of `wr_data_i` are ignored.
